// File: rtl/instr_fetch_master_if.sv
// Avalon-MM read-only bus between the instruction fetch master and memory.
// No latency of its own: signals only.
// The slave stalls the master by holding avm_waitrequest high.
interface instr_fetch_master_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        output avm_byteenable,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_byteenable,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/instr_fetch_master.sv
// Instruction fetch master: one Avalon-MM word read per fetch_req, with an optional byte swap.
// Latency: instr_valid comes 2 cycles after fetch_req with no waitrequest. READ_LATENCY=1 adds 1 cycle. Each wait edge adds 1 cycle.
// Backpressure: the request is held stable while waitrequest is high. fetch_req is dropped while busy, halted or errored.
module instr_fetch_master #(
    parameter int unsigned SWAP_BYTES     = 1,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                         clk_i,
    input  logic                         reset_i,        // active-low, asynchronous
    input  logic                         fetch_req_i,
    input  logic [31:0]                  pc_address_i,
    input  logic                         pc_halt_i,
    instr_fetch_master_if.master         avm,
    output logic [31:0]                  instr_o,
    output logic                         instr_valid_o,
    output logic                         busy_o,
    output logic                         halted_o,
    output logic                         fetch_error_o
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_HALTED = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    // Last wait-edge count before the timeout abort. It is unused when TIMEOUT_CYCLES is 0.
    localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        read_q, read_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    function automatic logic [31:0] fmt_word(input logic [31:0] d);
        if (SWAP_BYTES != 0)
            return {d[7:0], d[15:8], d[23:16], d[31:24]};
        else
            return d;
    endfunction

    // Next-state logic: walk the fetch FSM and decide what each register does on this edge.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        read_d   = read_q;
        be_d     = be_q;
        instr_d  = instr_q;
        valid_d  = 1'b0;
        halted_d = halted_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_req_i) begin
                    if (pc_halt_i) begin
                        halted_d = 1'b1;
                        state_d  = S_HALTED;
                    end else if (pc_address_i[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        addr_d  = pc_address_i;
                        read_d  = 1'b1;
                        be_d    = 4'hF;
                        cnt_d   = 32'd0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (!avm.avm_waitrequest) begin
                    read_d = 1'b0;
                    be_d   = 4'h0;
                    if (READ_LATENCY == 0) begin
                        instr_d = fmt_word(avm.avm_readdata);
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST)) begin
                    read_d  = 1'b0;
                    be_d    = 4'h0;
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DATA: begin
                instr_d = fmt_word(avm.avm_readdata);
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            S_HALTED, S_ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset drops the bus request immediately and abandons any read in flight.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            read_q   <= 1'b0;
            be_q     <= 4'h0;
            instr_q  <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            read_q   <= read_d;
            be_q     <= be_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign avm.avm_address    = addr_q;
    assign avm.avm_read       = read_q;
    assign avm.avm_byteenable = be_q;
    assign instr_o            = instr_q;
    assign instr_valid_o      = valid_q;
    assign busy_o             = (state_q == S_REQ) || (state_q == S_DATA);
    assign halted_o           = halted_q;
    assign fetch_error_o      = err_q;
endmodule

// File: tb/tb_instr_fetch_master.sv
// Testbench for instr_fetch_master, using two DUTs.
// dut0: byte swap on, READ_LATENCY=0, TIMEOUT_CYCLES=8.
// dut1: byte swap off, READ_LATENCY=1, no timeout.
module tb_instr_fetch_master;
    logic clk = 1'b0;
    logic reset_n = 1'b1;

    logic        fetch_req0 = 1'b0, pc_halt0 = 1'b0;
    logic [31:0] pc_address0 = 32'd0;
    logic [31:0] instr0;
    logic        instr_valid0, busy0, halted0, fetch_error0;

    logic        fetch_req1 = 1'b0, pc_halt1 = 1'b0;
    logic [31:0] pc_address1 = 32'd0;
    logic [31:0] instr1;
    logic        instr_valid1, busy1, halted1, fetch_error1;

    instr_fetch_master_if if0 ();
    instr_fetch_master_if if1 ();

    instr_fetch_master #(.SWAP_BYTES(1), .READ_LATENCY(0), .TIMEOUT_CYCLES(8)) dut0 (
        .clk_i(clk), .reset_i(reset_n), .fetch_req_i(fetch_req0), .pc_address_i(pc_address0),
        .pc_halt_i(pc_halt0), .avm(if0), .instr_o(instr0), .instr_valid_o(instr_valid0),
        .busy_o(busy0), .halted_o(halted0), .fetch_error_o(fetch_error0)
    );

    instr_fetch_master #(.SWAP_BYTES(0), .READ_LATENCY(1), .TIMEOUT_CYCLES(0)) dut1 (
        .clk_i(clk), .reset_i(reset_n), .fetch_req_i(fetch_req1), .pc_address_i(pc_address1),
        .pc_halt_i(pc_halt1), .avm(if1), .instr_o(instr1), .instr_valid_o(instr_valid1),
        .busy_o(busy1), .halted_o(halted1), .fetch_error_o(fetch_error1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cnt0 = 0;
    int valid_cnt1 = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] e0, e1;

    // Scoreboard: each instr_valid pulse pops the oldest expected word.
    always @(negedge clk) begin
        if (instr_valid0 === 1'b1) begin
            valid_cnt0++;
            n_tests++;
            if (exp_q0.size() == 0) begin
                n_fail++;
                $display("FAIL sb0_unexpected: instr_valid with instr=%h, required no pulse", instr0);
            end else begin
                e0 = exp_q0.pop_front();
                if (instr0 !== e0) begin
                    n_fail++;
                    $display("FAIL sb0_instr: got %h required %h", instr0, e0);
                end
            end
        end
        if (instr_valid1 === 1'b1) begin
            valid_cnt1++;
            n_tests++;
            if (exp_q1.size() == 0) begin
                n_fail++;
                $display("FAIL sb1_unexpected: instr_valid with instr=%h, required no pulse", instr1);
            end else begin
                e1 = exp_q1.pop_front();
                if (instr1 !== e1) begin
                    n_fail++;
                    $display("FAIL sb1_instr: got %h required %h", instr1, e1);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        fetch_req0 = 1'b0; pc_halt0 = 1'b0;
        fetch_req1 = 1'b0; pc_halt1 = 1'b0;
        if0.avm_waitrequest = 1'b0;
        if1.avm_waitrequest = 1'b0;
        reset_n = 1'b0;
        tick;
        tick;
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        if0.avm_waitrequest = 1'b0; if0.avm_readdata = 32'd0;
        if1.avm_waitrequest = 1'b0; if1.avm_readdata = 32'd0;
        #1 reset_n = 1'b0;
        #2;
        n_tests++;
        if ({if0.avm_address, if0.avm_read, if0.avm_byteenable, instr0, instr_valid0, busy0, halted0, fetch_error0} !== 73'd0) begin
            n_fail++;
            $display("FAIL reset_outputs0: got addr=%h rd=%b be=%h instr=%h v=%b busy=%b h=%b e=%b, required all 0",
                     if0.avm_address, if0.avm_read, if0.avm_byteenable, instr0, instr_valid0, busy0, halted0, fetch_error0);
        end
        n_tests++;
        if ({if1.avm_address, if1.avm_read, if1.avm_byteenable, instr1, instr_valid1, busy1, halted1, fetch_error1} !== 73'd0) begin
            n_fail++;
            $display("FAIL reset_outputs1: got nonzero outputs, required all 0");
        end
        tick;
        tick;
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        int v0;
        v0 = valid_cnt0;
        if0.avm_waitrequest = 1'b0;
        if0.avm_readdata = 32'h3412013C;
        fetch_req0 = 1'b1; pc_address0 = 32'hBFC00000;
        exp_q0.push_back(32'h3C011234);
        tick;
        fetch_req0 = 1'b0;
        n_tests++;
        if ({if0.avm_read, if0.avm_address, if0.avm_byteenable, busy0} !== {1'b1, 32'hBFC00000, 4'hF, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_req: got rd=%b addr=%h be=%h busy=%b, required 1 bfc00000 f 1",
                     if0.avm_read, if0.avm_address, if0.avm_byteenable, busy0);
        end
        tick;
        n_tests++;
        if ({if0.avm_read, if0.avm_byteenable, instr_valid0, instr0} !== {1'b0, 4'h0, 1'b1, 32'h3C011234}) begin
            n_fail++;
            $display("FAIL basic_capture: got rd=%b be=%h v=%b instr=%h, required 0 0 1 3c011234",
                     if0.avm_read, if0.avm_byteenable, instr_valid0, instr0);
        end
        tick;
        n_tests++;
        if ({instr_valid0, instr0, busy0} !== {1'b0, 32'h3C011234, 1'b0} || valid_cnt0 - v0 != 1) begin
            n_fail++;
            $display("FAIL basic_hold: got v=%b instr=%h busy=%b pulses=%0d, required 0 3c011234 0 1",
                     instr_valid0, instr0, busy0, valid_cnt0 - v0);
        end
    endtask

    task automatic test_wait_states;
        int v0;
        v0 = valid_cnt0;
        if0.avm_waitrequest = 1'b1;
        if0.avm_readdata = 32'hAABBCCDD;
        fetch_req0 = 1'b1; pc_address0 = 32'h00001000;
        exp_q0.push_back(32'hDDCCBBAA);
        tick;
        fetch_req0 = 1'b0;
        pc_address0 = 32'h0000FFFC;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({if0.avm_read, if0.avm_address, if0.avm_byteenable, busy0, instr_valid0} !== {1'b1, 32'h00001000, 4'hF, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL wait_hold[%0d]: got rd=%b addr=%h be=%h busy=%b v=%b, required 1 00001000 f 1 0",
                         k, if0.avm_read, if0.avm_address, if0.avm_byteenable, busy0, instr_valid0);
            end
            if (k == 3) if0.avm_waitrequest = 1'b0;
            tick;
        end
        n_tests++;
        if ({if0.avm_read, instr_valid0, busy0} !== {1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wait_accept: got rd=%b v=%b busy=%b, required 0 1 0", if0.avm_read, instr_valid0, busy0);
        end
        tick;
        n_tests++;
        if (valid_cnt0 - v0 != 1) begin
            n_fail++;
            $display("FAIL wait_pulses: got %0d required 1", valid_cnt0 - v0);
        end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = valid_cnt0;
        if0.avm_waitrequest = 1'b0;
        if0.avm_readdata = 32'h01020304;
        fetch_req0 = 1'b1; pc_address0 = 32'h00000100;
        exp_q0.push_back(32'h04030201);
        tick;
        fetch_req0 = 1'b0;
        tick;
        n_tests++;
        if (instr_valid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_valid: got %b required 1", instr_valid0);
        end
        fetch_req0 = 1'b1; pc_address0 = 32'h00000104;
        if0.avm_readdata = 32'h05060708;
        exp_q0.push_back(32'h08070605);
        tick;
        fetch_req0 = 1'b0;
        n_tests++;
        if ({if0.avm_read, if0.avm_address, instr_valid0} !== {1'b1, 32'h00000104, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_second_req: got rd=%b addr=%h v=%b, required 1 00000104 0",
                     if0.avm_read, if0.avm_address, instr_valid0);
        end
        tick;
        n_tests++;
        if ({instr_valid0, instr0} !== {1'b1, 32'h08070605}) begin
            n_fail++;
            $display("FAIL b2b_second_capture: got v=%b instr=%h, required 1 08070605", instr_valid0, instr0);
        end
        tick;
        n_tests++;
        if (valid_cnt0 - v0 != 2) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d required 2", valid_cnt0 - v0);
        end
    endtask

    task automatic test_ignore_busy;
        int v0;
        v0 = valid_cnt0;
        if0.avm_waitrequest = 1'b1;
        if0.avm_readdata = 32'hCAFEF00D;
        fetch_req0 = 1'b1; pc_address0 = 32'h00000200;
        exp_q0.push_back(32'h0DF0FECA);
        tick;
        pc_address0 = 32'h00000300;
        tick;
        fetch_req0 = 1'b0;
        n_tests++;
        if ({if0.avm_read, if0.avm_address} !== {1'b1, 32'h00000200}) begin
            n_fail++;
            $display("FAIL busy_ignore_addr: got rd=%b addr=%h, required 1 00000200", if0.avm_read, if0.avm_address);
        end
        if0.avm_waitrequest = 1'b0;
        tick;
        tick;
        n_tests++;
        if ({if0.avm_read, busy0, instr0} !== {1'b0, 1'b0, 32'h0DF0FECA} || valid_cnt0 - v0 != 1) begin
            n_fail++;
            $display("FAIL busy_ignore_single: got rd=%b busy=%b instr=%h pulses=%0d, required 0 0 0df0feca 1",
                     if0.avm_read, busy0, instr0, valid_cnt0 - v0);
        end
    endtask

    task automatic test_misaligned;
        int v0;
        int reads;
        v0 = valid_cnt0;
        reads = 0;
        fetch_req0 = 1'b1; pc_address0 = 32'hBFC00002;
        tick;
        fetch_req0 = 1'b0;
        n_tests++;
        if ({if0.avm_read, fetch_error0, busy0, halted0} !== {1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL misaligned_flag: got rd=%b err=%b busy=%b halt=%b, required 0 1 0 0",
                     if0.avm_read, fetch_error0, busy0, halted0);
        end
        fetch_req0 = 1'b1; pc_address0 = 32'hBFC00008;
        for (int i = 0; i < 4; i++) begin
            if (if0.avm_read === 1'b1) reads++;
            tick;
            fetch_req0 = 1'b0;
        end
        n_tests++;
        if (reads != 0 || fetch_error0 !== 1'b1 || valid_cnt0 != v0) begin
            n_fail++;
            $display("FAIL misaligned_sticky: got reads=%0d err=%b pulses=%0d, required 0 1 0",
                     reads, fetch_error0, valid_cnt0 - v0);
        end
        apply_reset;
    endtask

    task automatic test_halt;
        int reads;
        reads = 0;
        fetch_req0 = 1'b1; pc_halt0 = 1'b1; pc_address0 = 32'h00000000;
        tick;
        fetch_req0 = 1'b0; pc_halt0 = 1'b0;
        n_tests++;
        if ({halted0, if0.avm_read, fetch_error0, busy0} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_flag: got halt=%b rd=%b err=%b busy=%b, required 1 0 0 0",
                     halted0, if0.avm_read, fetch_error0, busy0);
        end
        fetch_req0 = 1'b1; pc_address0 = 32'h00000400;
        for (int i = 0; i < 4; i++) begin
            if (if0.avm_read === 1'b1) reads++;
            tick;
            fetch_req0 = 1'b0;
        end
        n_tests++;
        if (reads != 0 || halted0 !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_terminal: got reads=%0d halt=%b, required 0 1", reads, halted0);
        end
        apply_reset;
    endtask

    task automatic test_timeout;
        int v0;
        int reads;
        v0 = valid_cnt0;
        reads = 0;
        if0.avm_waitrequest = 1'b1;
        fetch_req0 = 1'b1; pc_address0 = 32'h00000500;
        tick;
        fetch_req0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if0.avm_read === 1'b1) reads++;
            tick;
        end
        n_tests++;
        if (reads != 8) begin
            n_fail++;
            $display("FAIL timeout_read_cycles: got %0d required 8", reads);
        end
        n_tests++;
        if ({fetch_error0, busy0, if0.avm_byteenable} !== {1'b1, 1'b0, 4'h0} || valid_cnt0 != v0) begin
            n_fail++;
            $display("FAIL timeout_flag: got err=%b busy=%b be=%h pulses=%0d, required 1 0 0 0",
                     fetch_error0, busy0, if0.avm_byteenable, valid_cnt0 - v0);
        end
        apply_reset;
    endtask

    task automatic test_reset_midreq;
        if0.avm_waitrequest = 1'b1;
        fetch_req0 = 1'b1; pc_address0 = 32'h00000600;
        tick;
        fetch_req0 = 1'b0;
        n_tests++;
        if (if0.avm_read !== 1'b1) begin
            n_fail++;
            $display("FAIL midreq_pre: got rd=%b required 1", if0.avm_read);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({if0.avm_address, if0.avm_read, if0.avm_byteenable, instr0, instr_valid0, busy0, halted0, fetch_error0} !== 73'd0) begin
            n_fail++;
            $display("FAIL midreq_async: got addr=%h rd=%b be=%h instr=%h busy=%b, required all 0",
                     if0.avm_address, if0.avm_read, if0.avm_byteenable, instr0, busy0);
        end
        tick;
        reset_n = 1'b1;
        if0.avm_waitrequest = 1'b0;
        if0.avm_readdata = 32'h11223344;
        tick;
        fetch_req0 = 1'b1; pc_address0 = 32'hBFC00004;
        exp_q0.push_back(32'h44332211);
        tick;
        fetch_req0 = 1'b0;
        n_tests++;
        if ({if0.avm_read, if0.avm_address} !== {1'b1, 32'hBFC00004}) begin
            n_fail++;
            $display("FAIL midreq_refetch_req: got rd=%b addr=%h, required 1 bfc00004", if0.avm_read, if0.avm_address);
        end
        tick;
        n_tests++;
        if ({instr_valid0, instr0} !== {1'b1, 32'h44332211}) begin
            n_fail++;
            $display("FAIL midreq_refetch_data: got v=%b instr=%h, required 1 44332211", instr_valid0, instr0);
        end
        tick;
    endtask

    task automatic test_latency1;
        if1.avm_waitrequest = 1'b0;
        if1.avm_readdata = 32'h11223344;
        fetch_req1 = 1'b1; pc_address1 = 32'hBFC00004;
        exp_q1.push_back(32'h11223344);
        tick;
        fetch_req1 = 1'b0;
        n_tests++;
        if ({if1.avm_read, if1.avm_address, busy1} !== {1'b1, 32'hBFC00004, 1'b1}) begin
            n_fail++;
            $display("FAIL lat1_req: got rd=%b addr=%h busy=%b, required 1 bfc00004 1", if1.avm_read, if1.avm_address, busy1);
        end
        tick;
        n_tests++;
        if ({if1.avm_read, busy1, instr_valid1} !== {1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL lat1_bubble: got rd=%b busy=%b v=%b, required 0 1 0", if1.avm_read, busy1, instr_valid1);
        end
        tick;
        n_tests++;
        if ({instr_valid1, instr1, busy1} !== {1'b1, 32'h11223344, 1'b0}) begin
            n_fail++;
            $display("FAIL lat1_capture: got v=%b instr=%h busy=%b, required 1 11223344 0", instr_valid1, instr1, busy1);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wait_states;
        test_back_to_back;
        test_ignore_busy;
        test_misaligned;
        test_halt;
        test_timeout;
        test_reset_midreq;
        test_latency1;
        tick;
        n_tests++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d/%0d words outstanding, required 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
